// File: rtl/lanzones_regfile.sv
// lanzones_regfile: 2R/1W integer register file with per-register pending-write scoreboard.
// Define LANZONES_RF_BYPASS_EN to forward a same-cycle write into the read ports.
module lanzones_regfile #(
   parameter int XLEN     = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            rs1_en,
   input  logic [AW-1:0]   rs1_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic            rs1_busy,
   input  logic            rs2_en,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs2_busy,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_rd,
   output logic [AW:0]     pend_cnt,
   output logic            wb_err
);
   localparam int N = 1 << AW;
   logic [XLEN-1:0] regs [N];
   logic [N-1:0]    busy, busy_n;
   logic            wr_v, iss_v, inc, dec;
   logic [XLEN-1:0] rd1, rd2;
   logic            bz1, bz2;
   always_comb begin
      wr_v   = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
      iss_v  = iss_en && !(ZERO_REG != 0 && iss_rd == '0);
      inc    = iss_v && !busy[iss_rd];
      // a busy register written and re-issued in the same cycle stays counted
      dec    = wr_v && busy[wr_addr] && !(iss_v && iss_rd == wr_addr);
      busy_n = busy;
      if (wr_v) busy_n[wr_addr] = 1'b0;
      if (iss_v) busy_n[iss_rd] = 1'b1;
`ifdef LANZONES_RF_BYPASS_EN
      rd1 = (wr_v && wr_addr == rs1_addr) ? wr_data : regs[rs1_addr];
      bz1 = (wr_v && wr_addr == rs1_addr) ? 1'b0 : busy[rs1_addr];
      rd2 = (wr_v && wr_addr == rs2_addr) ? wr_data : regs[rs2_addr];
      bz2 = (wr_v && wr_addr == rs2_addr) ? 1'b0 : busy[rs2_addr];
`else
      rd1 = regs[rs1_addr];
      bz1 = busy[rs1_addr];
      rd2 = regs[rs2_addr];
      bz2 = busy[rs2_addr];
`endif
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N; i++) regs[i] <= '0;
         busy     <= '0;
         rs1_data <= '0;
         rs1_busy <= 1'b0;
         rs2_data <= '0;
         rs2_busy <= 1'b0;
         pend_cnt <= '0;
         wb_err   <= 1'b0;
      end else begin
         if (wr_v) regs[wr_addr] <= wr_data;
         busy <= busy_n;
         if (rs1_en) begin
            rs1_data <= rd1;
            rs1_busy <= bz1;
         end
         if (rs2_en) begin
            rs2_data <= rd2;
            rs2_busy <= bz2;
         end
         pend_cnt <= pend_cnt + (AW+1)'(inc) - (AW+1)'(dec);
         if (wr_v && !busy[wr_addr]) wb_err <= 1'b1;
      end
   end
endmodule

// File: doc/lanzones_regfile.md
# lanzones_regfile

Parametrised integer register file for the lanzones RISC-V core. It replaces the single-port, 32-entry, address-decoded register bank with two registered read ports and one write port, and a hardwired-zero register. It also adds a per-register pending-write scoreboard, so the decode stage can detect RAW hazards against instructions still in flight. The block sits between decode (reads and issue marks) and writeback (writes).

## Interface
Parameters:
- XLEN, 32, data width of each register.
- AW, 5, address width; the file holds 2**AW registers.
- ZERO_REG, 1, when 1, register 0 reads as zero, is never written and is never busy.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- rs1_en  in  1  capture read port 1 this cycle.
- rs1_addr  in  AW  read port 1 address.
- rs1_data  out  XLEN  registered read data, port 1.
- rs1_busy  out  1  registered pending-write flag for the rs1_addr captured with rs1_data.
- rs2_en, rs2_addr, rs2_data, rs2_busy: same as port 1, independent.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- iss_en  in  1  an instruction with destination iss_rd has issued; mark it pending.
- iss_rd  in  AW  destination register of the issuing instruction.
- pend_cnt  out  AW+1  number of registers currently marked pending.
- wb_err  out  1  sticky flag: a write arrived for a register that was not pending.

## Operation
- Storage: 2**AW × XLEN flops, plus a busy[2**AW] bit vector.
- Write: when wr_en is high, reg[wr_addr] <= wr_data and busy[wr_addr] is cleared. Exception: with ZERO_REG=1 and wr_addr==0, the write is ignored entirely.
- Issue: when iss_en is high, busy[iss_rd] <= 1. With ZERO_REG=1 and iss_rd==0, the issue is ignored.
- Same-cycle issue and write to the same register: set wins, because the new issue supersedes the retiring write. The data is still written.
- Read, port N: when rsN_en is high, rsN_data <= value(rsN_addr) and rsN_busy <= pend(rsN_addr). When rsN_en is low, both outputs hold.
- Reads see state after any same-cycle write handling (see Configuration) and before any same-cycle issue. An issue in cycle t never sets rsN_busy captured in cycle t.
- Register 0 with ZERO_REG=1: rsN_data captures 0 and rsN_busy captures 0.
- pend_cnt tracks the net change each cycle:
  - +1 when a non-busy register is set.
  - −1 when a busy register is cleared and not re-set in the same cycle.
  - Net 0 when both happen on the same register, or on a set and a clear to different registers.
- The counter never wraps: its maximum is 2**AW − ZERO_REG.
- wb_err is set when wr_en is high for a register that is not busy (address 0 excluded when ZERO_REG=1). It clears only on reset.

## Timing
- Read latency: 1 cycle. rsN_en sampled at edge t produces rsN_data and rsN_busy valid after edge t.
- Write visibility without bypass: a write at edge t is readable by a capture at edge t+1.
- Issue visibility: a busy set at edge t is visible to a capture at edge t+1.
- Asynchronous reset (rstn low), effective immediately, no clock needed:
  - all registers = 0, busy = 0;
  - rs1_data, rs2_data = 0; rs1_busy, rs2_busy = 0;
  - pend_cnt = 0, wb_err = 0.
- Reset asserted mid-operation discards all pending marks. Writes after reset deassertion to registers not marked pending set wb_err.
- Reset deassertion must be synchronised externally. The first edge after release is a normal cycle.

## Configuration
- LANZONES_RF_BYPASS_EN defined: a read in the same cycle as a write to the same (non-zero) address captures wr_data, and captures busy as already cleared. If an issue also targets that address in the same cycle, rsN_busy still captures 0.
- LANZONES_RF_BYPASS_EN undefined: that read captures the old register value and the old busy bit. Decode must stall one cycle.

## Test plan
- Reset then read: reset, capture rs1=5 and rs2=31 → both data 0, busy 0, pend_cnt 0, wb_err 0.
- Write/read with both ports: iss_rd=3, then wr 3 ← 0xDEADBEEF, then capture rs1=3 and rs2=3 next cycle → both 0xDEADBEEF, busy 0, pend_cnt 1→0.
- Register zero: iss_rd=0 and wr 0 ← 0x1234 → rs1=0 reads 0, busy 0, pend_cnt 0, wb_err 0.
- Same-cycle write+read on reg 7, holding 0x11, write 0x22:
  - bypass build → rs1_data 0x22, busy 0;
  - non-bypass build → 0x11, busy 1.
- Scoreboard:
  - issue 1, 2, 3 → pend_cnt 3;
  - same-cycle issue 2 + write 2 → pend_cnt 3, busy[2] 1;
  - write 5 (never issued) → wb_err 1, pend_cnt 3;
  - assert rstn low mid-sequence → pend_cnt 0, wb_err 0 immediately.
- Hold: capture rs1=4 (value 0x55), drop rs1_en, write 4 ← 0x66 → rs1_data stays 0x55 until rs1_en is reasserted.
